sdp_x_chn_in_wait_fifo: RTL and testbench

//  Parametrised input-channel interface for SDP X core datapaths (mul/alu operand channels).

---
 rtl/sdp_x_chn_in_wait_fifo.sv | 122 ++++++++++++
 tb/tb_sdp_x_chn_in_wait_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_x_chn_in_wait_fifo.sv
// SDP X operand-channel input buffer: DEPTH-entry elastic FIFO between the channel pipe and the core loop.
// Optional zero-latency empty bypass is enabled by defining SDP_X_CHN_IN_BYPASS_EN.
module sdp_x_chn_in_wait_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 2,
    parameter int CNTW  = $clog2(DEPTH + 1)
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rst,
    input  logic [WIDTH-1:0] chn_rsc_z,
    input  logic             chn_rsc_vz,
    output logic             chn_rsc_lz,
    input  logic             chn_rsci_oswt,
    output logic             chn_rsci_bawt,
    output logic             chn_rsci_wen_comp,
    output logic [WIDTH-1:0] chn_rsci_d_mxwt,
    output logic [CNTW-1:0]  chn_rsci_cnt
);

    localparam int              PTRW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
    localparam logic [PTRW-1:0] LAST_PTR = PTRW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTRW-1:0]  r_wr_ptr;
    logic [PTRW-1:0]  r_rd_ptr;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_last;

    logic             w_empty;
    logic             w_full;
    logic             w_lz;
    logic             w_byp;
    logic             w_bawt;
    logic             w_push;
    logic             w_pop;
    logic             w_wr;
    logic             w_rd;
    logic [WIDTH-1:0] w_head;
    logic [WIDTH-1:0] w_d;

    assign w_empty = (r_cnt == '0);
    assign w_full  = (r_cnt == FULL_CNT);

    // Ready depends only on reset and registered occupancy, so a full buffer
    // cannot re-open in the same cycle that it pops.
    assign w_lz   = ~nvdla_core_rst & ~w_full;
    assign w_push = chn_rsc_vz & w_lz;

`ifdef SDP_X_CHN_IN_BYPASS_EN
    assign w_byp = w_empty & chn_rsc_vz & ~nvdla_core_rst;
`else
    assign w_byp = 1'b0;
`endif

    assign w_bawt = ~w_empty | w_byp;
    assign w_pop  = chn_rsci_oswt & w_bawt;

    // A bypassed word consumed by the core never touches storage.
    assign w_wr = w_push & ~(w_byp & chn_rsci_oswt);
    assign w_rd = w_pop & ~w_empty;

    assign w_head = r_mem[r_rd_ptr];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_d = r_last;
        if (!w_empty) begin
            w_d = w_head;
        end else if (w_byp) begin
            w_d = chn_rsc_z;
        end
    end

    // NOTE: storage is not reset; only the pointers and count that qualify it are.
    always_ff @(posedge nvdla_core_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= chn_rsc_z;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_last   <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_pop) begin
                r_last <= w_d;
            end
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign chn_rsc_lz        = w_lz;
    assign chn_rsci_bawt     = w_bawt;
    assign chn_rsci_wen_comp = ~chn_rsci_oswt | w_bawt;
    assign chn_rsci_d_mxwt   = w_d;
    assign chn_rsci_cnt      = r_cnt;

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        w_wr |-> !w_full);
    a_no_pop_empty: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        w_rd |-> !w_empty);
    a_cnt_range: assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        r_cnt <= FULL_CNT);
`endif

endmodule

// File: tb/tb_sdp_x_chn_in_wait_fifo.sv
// Scoreboard bench for sdp_x_chn_in_wait_fifo: reset, fill, full+pop, stall, empty-path latency, stream, mid-burst reset.
module tb_sdp_x_chn_in_wait_fifo;

    parameter int WIDTH = 256;
    parameter int DEPTH = 2;
    localparam int CNTW = $clog2(DEPTH + 1);

`ifdef SDP_X_CHN_IN_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] z;
    logic             vz;
    logic             lz;
    logic             oswt;
    logic             bawt;
    logic             wen_comp;
    logic [WIDTH-1:0] d_mxwt;
    logic [CNTW-1:0]  cnt;

    sdp_x_chn_in_wait_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .nvdla_core_clk    (clk),
        .nvdla_core_rst    (rst),
        .chn_rsc_z         (z),
        .chn_rsc_vz        (vz),
        .chn_rsc_lz        (lz),
        .chn_rsci_oswt     (oswt),
        .chn_rsci_bawt     (bawt),
        .chn_rsci_wen_comp (wen_comp),
        .chn_rsci_d_mxwt   (d_mxwt),
        .chn_rsci_cnt      (cnt)
    );

    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_fail   = 0;
    int               n_pops   = 0;
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] src_q [$];
    logic [WIDTH-1:0] m_last;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rnd();
        logic [WIDTH-1:0] w = '0;
        for (int i = 0; i < (WIDTH + 31) / 32; i++) begin
            w = (w << 32) ^ WIDTH'($urandom());
        end
        return w;
    endfunction

    task automatic drive();
        vz = (src_q.size() != 0);
        z  = vz ? src_q[0] : '0;
    endtask

    // One clock: check every output against the model mid-cycle, then advance model and DUT.
    task automatic step();
        int               m_cnt;
        logic             m_lz;
        logic             m_byp;
        logic             m_bawt;
        logic [WIDTH-1:0] m_d;
        logic [WIDTH-1:0] w;
        drive();
        @(negedge clk);
        m_cnt  = exp_q.size();
        m_lz   = !rst && (m_cnt != DEPTH);
        m_byp  = BYP && (m_cnt == 0) && vz && !rst;
        m_bawt = (m_cnt != 0) || m_byp;
        m_d    = (m_cnt != 0) ? exp_q[0] : (m_byp ? z : m_last);
        check("lz", WIDTH'(lz), WIDTH'(m_lz));
        check("bawt", WIDTH'(bawt), WIDTH'(m_bawt));
        check("wen_comp", WIDTH'(wen_comp), WIDTH'(!oswt || m_bawt));
        check("cnt", WIDTH'(cnt), WIDTH'(m_cnt));
        check("d_mxwt", d_mxwt, m_d);
        if (oswt && m_bawt) begin
            w = (m_cnt != 0) ? exp_q.pop_front() : z;
            check("pop_data", d_mxwt, w);
            m_last = w;
            n_pops++;
        end
        if (vz && m_lz) begin
            if (!(m_byp && oswt)) exp_q.push_back(z);
            void'(src_q.pop_front());
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    initial begin
        int n_fill;
        int cycles;
        int exp_cyc;
        rst    = 1'b1;
        vz     = 1'b0;
        z      = '0;
        oswt   = 1'b0;
        m_last = '0;

        // Reset state
        #2;
        check("rst_lz", WIDTH'(lz), WIDTH'(1'b0));
        check("rst_bawt", WIDTH'(bawt), WIDTH'(1'b0));
        check("rst_cnt", WIDTH'(cnt), '0);
        check("rst_d", d_mxwt, '0);
        check("rst_wen_idle", WIDTH'(wen_comp), WIDTH'(1'b1));
        oswt = 1'b1;
        #1;
        check("rst_wen_req", WIDTH'(wen_comp), WIDTH'(1'b0));
        oswt = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rel_lz", WIDTH'(lz), WIDTH'(1'b1));

        // Fill with core idle, third word waits, then drain in order
        src_q.push_back(WIDTH'(8'hA1));
        src_q.push_back(WIDTH'(8'hB2));
        src_q.push_back(WIDTH'(8'hC3));
        n_fill = (DEPTH < 3) ? DEPTH : 3;
        repeat (DEPTH + 3) step();
        check("fill_cnt", WIDTH'(cnt), WIDTH'(n_fill));
        check("fill_lz", WIDTH'(lz), WIDTH'(DEPTH > 3));
        n_pops = 0;
        oswt   = 1'b1;
        repeat (DEPTH + 6) step();
        check("fill_pops", WIDTH'(n_pops), WIDTH'(3));
        check("fill_empty", WIDTH'(cnt), '0);
        check("fill_hold_last", d_mxwt, WIDTH'(8'hC3));

        // Full with a word pending, then a single pop
        oswt = 1'b0;
        repeat (DEPTH + 1) src_q.push_back(rnd());
        repeat (DEPTH + 1) step();
        check("full_cnt", WIDTH'(cnt), WIDTH'(DEPTH));
        check("full_lz", WIDTH'(lz), WIDTH'(1'b0));
        oswt = 1'b1;
        step();
        oswt = 1'b0;
        #1;
        check("fullpop_cnt", WIDTH'(cnt), WIDTH'(DEPTH - 1));
        check("fullpop_lz", WIDTH'(lz), WIDTH'(1'b1));
        oswt = 1'b1;
        repeat (DEPTH + 3) step();
        check("fullpop_drain", WIDTH'(cnt), '0);

        // Core stalls on an empty buffer until a word lands
        repeat (3) step();
        check("stall_wen", WIDTH'(wen_comp), WIDTH'(1'b0));
        src_q.push_back(WIDTH'(8'h3C));
        step();
`ifndef SDP_X_CHN_IN_BYPASS_EN
        check("stall_land_wen", WIDTH'(wen_comp), WIDTH'(1'b1));
        check("stall_land_d", d_mxwt, WIDTH'(8'h3C));
        step();
`endif
        check("stall_after_wen", WIDTH'(wen_comp), WIDTH'(1'b0));
        check("stall_after_d", d_mxwt, WIDTH'(8'h3C));

        // Empty-path latency for a single word with the core requesting
        src_q.push_back(WIDTH'(8'h5A));
        drive();
        #1;
`ifdef SDP_X_CHN_IN_BYPASS_EN
        check("byp_bawt", WIDTH'(bawt), WIDTH'(1'b1));
        check("byp_d", d_mxwt, WIDTH'(8'h5A));
        step();
        check("byp_cnt", WIDTH'(cnt), '0);
`else
        check("nobyp_bawt", WIDTH'(bawt), WIDTH'(1'b0));
        step();
        check("nobyp_bawt_next", WIDTH'(bawt), WIDTH'(1'b1));
        check("nobyp_d_next", d_mxwt, WIDTH'(8'h5A));
        step();
`endif

        // Continuous stream of 100 words
        n_pops = 0;
        cycles = 0;
        for (int i = 0; i < 100; i++) src_q.push_back(rnd());
        exp_cyc = BYP ? 100 : ((DEPTH >= 2) ? 101 : 200);
        while (n_pops < 100 && cycles < 400) begin
            step();
            cycles++;
        end
        check("stream_pops", WIDTH'(n_pops), WIDTH'(100));
        check("stream_cycles", WIDTH'(cycles), WIDTH'(exp_cyc));

        // Reset in the middle of a burst discards everything
        oswt = 1'b0;
        repeat (3) src_q.push_back(rnd());
        repeat (3) step();
        check("midrst_pre_cnt", WIDTH'(cnt), WIDTH'(n_fill));
        rst = 1'b1;
        #1;
        check("midrst_lz", WIDTH'(lz), WIDTH'(1'b0));
        check("midrst_bawt", WIDTH'(bawt), WIDTH'(1'b0));
        check("midrst_cnt", WIDTH'(cnt), '0);
        check("midrst_d", d_mxwt, '0);
        exp_q.delete();
        src_q.delete();
        m_last = '0;
        repeat (2) step();
        rst = 1'b0;
        #1;
        check("midrst_rel_lz", WIDTH'(lz), WIDTH'(1'b1));
        oswt = 1'b1;
        repeat (3) step();
        src_q.push_back(rnd());
        repeat (3) step();
        check("post_rst_empty", WIDTH'(cnt), '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
